// File: rtl/mac_array_ctrl.sv
// Sequencer for a chain of mac_col columns: loads kernel rows, waits out the
// propagation gap, streams query rows, then waits for every psum write to come back.
module mac_array_ctrl #(
   parameter int bw      = 8,
   parameter int pr      = 8,
   parameter int col     = 8,
   parameter int aw      = 4,
   parameter int gap_cyc = 8,
   parameter int to_cyc  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [aw:0]       num_q,
   input  logic              ofifo_full,
   input  logic              psum_wr,
   output logic              kmem_ren,
   output logic [aw-1:0]     kmem_addr,
   input  logic [bw*pr-1:0]  kmem_rdata,
   output logic              qmem_ren,
   output logic [aw-1:0]     qmem_addr,
   input  logic [bw*pr-1:0]  qmem_rdata,
   output logic [bw*pr-1:0]  q_in,
   output logic [1:0]        i_inst,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic [aw:0]       wr_cnt
);

   localparam int cnt_max = (gap_cyc > to_cyc) ? gap_cyc : to_cyc;
   localparam int cnt_w   = $clog2(cnt_max + 1);
   localparam logic [aw:0] wr_max = {1'b1, {aw{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GAP   = 3'd2,
      S_EXEC  = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic [cnt_w-1:0]  cnt, cnt_nxt;
   logic [aw:0]       icnt, icnt_nxt;
   logic [aw:0]       nq, nq_nxt;
   logic [aw:0]       wr_nxt;
   logic              err_nxt;
   logic              kren_nxt, qren_nxt;
   logic [aw-1:0]     kaddr_nxt, qaddr_nxt;
   logic [1:0]        inst_d1;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Read enables are decided one cycle ahead so ren/addr leave the block registered;
   // in EXEC, icnt is both the issued count and the next address to read.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      icnt_nxt  = icnt;
      nq_nxt    = nq;
      err_nxt   = err_timeout;
      wr_nxt    = wr_cnt;
      kren_nxt  = 1'b0;
      kaddr_nxt = '0;
      qren_nxt  = 1'b0;
      qaddr_nxt = '0;
      if (psum_wr && state != S_IDLE && wr_cnt != wr_max) wr_nxt = wr_cnt + 1'b1;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_LOAD;
               nq_nxt    = num_q;
               wr_nxt    = '0;
               err_nxt   = 1'b0;
               kren_nxt  = 1'b1;
            end
         end
         S_LOAD: begin
            if (kmem_addr == aw'(col - 1)) begin
               state_nxt = S_GAP;
               cnt_nxt   = '0;
            end else begin
               kren_nxt  = 1'b1;
               kaddr_nxt = kmem_addr + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt == cnt_w'(gap_cyc - 1)) begin
               cnt_nxt  = '0;
               icnt_nxt = '0;
               if (nq == '0) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_EXEC;
                  qren_nxt  = !ofifo_full;
                  if (!ofifo_full) icnt_nxt = (aw+1)'(1);
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_EXEC: begin
            if (icnt == nq) begin
               state_nxt = S_DRAIN;
               cnt_nxt   = '0;
            end else begin
               qaddr_nxt = icnt[aw-1:0];
               qren_nxt  = !ofifo_full;
               if (!ofifo_full) icnt_nxt = icnt + 1'b1;
            end
         end
         S_DRAIN: begin
            // Drain started the cycle after the last issue, so to_cyc-2 lands done
            // exactly to_cyc cycles after that issue.
            if (wr_nxt >= nq) begin
               state_nxt = S_DONE;
            end else if (cnt == cnt_w'(to_cyc - 2)) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         icnt        <= '0;
         nq          <= '0;
         wr_cnt      <= '0;
         err_timeout <= 1'b0;
         kmem_ren    <= 1'b0;
         kmem_addr   <= '0;
         qmem_ren    <= 1'b0;
         qmem_addr   <= '0;
         inst_d1     <= 2'b00;
         i_inst      <= 2'b00;
         q_in        <= '0;
      end else begin
         cnt         <= cnt_nxt;
         icnt        <= icnt_nxt;
         nq          <= nq_nxt;
         wr_cnt      <= wr_nxt;
         err_timeout <= err_nxt;
         kmem_ren    <= kren_nxt;
         kmem_addr   <= kaddr_nxt;
         qmem_ren    <= qren_nxt;
         qmem_addr   <= qaddr_nxt;
         // inst_d1 travels alongside the SRAM read so it lines up with rdata.
         inst_d1     <= kmem_ren ? 2'b01 : (qmem_ren ? 2'b10 : 2'b00);
         i_inst      <= inst_d1;
         case (inst_d1)
            2'b01:   q_in <= kmem_rdata;
            2'b10:   q_in <= qmem_rdata;
            default: q_in <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: SRAM models, per-cycle expected i_inst/q_in stream in a
// queue, and one task per scenario with inline checks on control outputs.
module tb_mac_array_ctrl;

   localparam int bw_p  = 8;
   localparam int pr_p  = 8;
   localparam int col_p = 3;
   localparam int aw_p  = 4;
   localparam int gap_p = 4;
   localparam int to_p  = 10;
   localparam int dw    = bw_p * pr_p;

   logic              clk;
   logic              reset;
   logic              start;
   logic [aw_p:0]     num_q;
   logic              ofifo_full;
   logic              psum_wr;
   logic              kmem_ren;
   logic [aw_p-1:0]   kmem_addr;
   logic [dw-1:0]     kmem_rdata;
   logic              qmem_ren;
   logic [aw_p-1:0]   qmem_addr;
   logic [dw-1:0]     qmem_rdata;
   logic [dw-1:0]     q_in;
   logic [1:0]        i_inst;
   logic              busy;
   logic              done;
   logic              err_timeout;
   logic [aw_p:0]     wr_cnt;

   logic [dw-1:0]     kmem [16];
   logic [dw-1:0]     qmem [16];
   logic [dw+1:0]     exp_q[$];
   logic [dw+1:0]     exp_beat;
   logic              mon_en;
   int                n_checks;
   int                n_fails;

   mac_array_ctrl #(
      .bw(bw_p), .pr(pr_p), .col(col_p), .aw(aw_p), .gap_cyc(gap_p), .to_cyc(to_p)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .num_q(num_q),
      .ofifo_full(ofifo_full), .psum_wr(psum_wr),
      .kmem_ren(kmem_ren), .kmem_addr(kmem_addr), .kmem_rdata(kmem_rdata),
      .qmem_ren(qmem_ren), .qmem_addr(qmem_addr), .qmem_rdata(qmem_rdata),
      .q_in(q_in), .i_inst(i_inst), .busy(busy), .done(done),
      .err_timeout(err_timeout), .wr_cnt(wr_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (kmem_ren) kmem_rdata <= kmem[kmem_addr];
      if (qmem_ren) qmem_rdata <= qmem[qmem_addr];
   end

   // Stream scoreboard: one entry per cycle from the start pulse; an empty queue means idle.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_beat = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         n_checks++;
         if ({i_inst, q_in} !== exp_beat) begin
            n_fails++;
            $display("FAIL stream @%0t: got inst=%b q_in=%h want inst=%b q_in=%h",
                     $time, i_inst, q_in, exp_beat[dw+1:dw], exp_beat[dw-1:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected stream for a run whose start pulse is in the current cycle (offset 0).
   // ofifo_full is high at offsets sa..sa+sl-1; an issue at offset c needs it low at c-1.
   task automatic plan_run(input int nq, input int sa, input int sl);
      int issued;
      int c;
      for (int i = 0; i < 16; i++) begin
         kmem[i] = {$urandom, $urandom};
         qmem[i] = {$urandom, $urandom};
      end
      for (int i = 0; i < 3; i++) exp_q.push_back('0);
      for (int i = 0; i < col_p; i++) exp_q.push_back({2'b01, kmem[i]});
      for (int i = 0; i < gap_p; i++) exp_q.push_back('0);
      issued = 0;
      c = 1 + col_p + gap_p;
      while (issued < nq) begin
         if (c - 1 >= sa && c - 1 < sa + sl) begin
            exp_q.push_back('0);
         end else begin
            exp_q.push_back({2'b10, qmem[issued]});
            issued++;
         end
         c++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; num_q = '0; ofifo_full = 1'b0; psum_wr = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({kmem_ren, kmem_addr, qmem_ren, qmem_addr, q_in, i_inst, busy, done,
           err_timeout, wr_cnt} !== '0) begin
         n_fails++;
         $display("FAIL reset_outputs: got ren=%b/%b addr=%h/%h inst=%b busy=%b done=%b err=%b wr=%0d want all 0",
                  kmem_ren, qmem_ren, kmem_addr, qmem_addr, i_inst, busy, done, err_timeout, wr_cnt);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (busy !== 1'b0 || kmem_ren !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_idle: got busy=%b kmem_ren=%b want 0 0", busy, kmem_ren);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      int kren_n, qren_n, done_n, done_at;
      kren_n = 0; qren_n = 0; done_n = 0; done_at = -1;
      plan_run(3, -100, 0);
      for (int t = 0; t < 24; t++) begin
         start = (t == 0); num_q = 5'd3;
         psum_wr = (t == 13 || t == 15 || t == 17);
         if (kmem_ren) begin
            n_checks++;
            if (kmem_addr !== 4'(kren_n) || t != kren_n + 1) begin
               n_fails++;
               $display("FAIL basic_kaddr: got addr=%0d at offset %0d want addr=%0d at offset %0d",
                        kmem_addr, t, kren_n, kren_n + 1);
            end
            kren_n++;
         end
         if (qmem_ren) qren_n++;
         if (done) begin done_n++; if (done_at < 0) done_at = t; end
         if (t == 18) begin
            n_checks++;
            if (wr_cnt !== 5'd3 || busy !== 1'b1) begin
               n_fails++;
               $display("FAIL basic_done_state: got wr_cnt=%0d busy=%b want 3 1", wr_cnt, busy);
            end
         end
         if (t == 19) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fails++;
               $display("FAIL basic_busy_fall: got %b want 0", busy);
            end
         end
         step();
      end
      n_checks++;
      if (kren_n != 3 || qren_n != 3 || done_n != 1 || done_at != 18) begin
         n_fails++;
         $display("FAIL basic_counts: got kren=%0d qren=%0d done_n=%0d done_at=%0d want 3 3 1 18",
                  kren_n, qren_n, done_n, done_at);
      end
   endtask

   task automatic test_stall();
      int qren_n, done_at;
      qren_n = 0; done_at = -1;
      plan_run(4, 9, 2);
      for (int t = 0; t < 26; t++) begin
         start = (t == 0); num_q = 5'd4;
         ofifo_full = (t == 9 || t == 10);
         psum_wr = (t == 12 || t == 16 || t == 17 || t == 18);
         if (qmem_ren) qren_n++;
         if (done && done_at < 0) done_at = t;
         if (t == 10 || t == 11) begin
            n_checks++;
            if (qmem_ren !== 1'b0 || qmem_addr !== 4'd2) begin
               n_fails++;
               $display("FAIL stall_hold: offset %0d got ren=%b addr=%0d want 0 2", t, qmem_ren, qmem_addr);
            end
         end
         if (t == 13) begin
            n_checks++;
            if (wr_cnt !== 5'd1 || qmem_ren !== 1'b1 || qmem_addr !== 4'd3) begin
               n_fails++;
               $display("FAIL stall_last_issue: got wr_cnt=%0d ren=%b addr=%0d want 1 1 3",
                        wr_cnt, qmem_ren, qmem_addr);
            end
         end
         step();
      end
      ofifo_full = 1'b0;
      n_checks++;
      if (qren_n != 4 || done_at != 19) begin
         n_fails++;
         $display("FAIL stall_counts: got qren=%0d done_at=%0d want 4 19", qren_n, done_at);
      end
   endtask

   task automatic test_zero_q();
      int kren_n, qren_n, done_at;
      kren_n = 0; qren_n = 0; done_at = -1;
      plan_run(0, -100, 0);
      for (int t = 0; t < 12; t++) begin
         start = (t == 0); num_q = 5'd0; psum_wr = 1'b0;
         if (kmem_ren) kren_n++;
         if (qmem_ren) qren_n++;
         if (done && done_at < 0) done_at = t;
         if (t == 9) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fails++;
               $display("FAIL zero_busy: got %b want 0", busy);
            end
         end
         step();
      end
      n_checks++;
      if (kren_n != 3 || qren_n != 0 || done_at != 8) begin
         n_fails++;
         $display("FAIL zero_counts: got kren=%0d qren=%0d done_at=%0d want 3 0 8", kren_n, qren_n, done_at);
      end
   endtask

   task automatic test_start_ignored();
      int done_n, done_a, done_b;
      done_n = 0; done_a = -1; done_b = -1;
      plan_run(2, -100, 0);
      for (int t = 0; t < 32; t++) begin
         start = (t == 0 || t == 9 || t == 13 || t == 14);
         num_q = (t == 0) ? 5'd2 : ((t == 14) ? 5'd1 : 5'd5);
         psum_wr = (t == 11 || t == 12 || t == 25);
         if (t == 14) plan_run(1, -100, 0);
         if (done) begin
            if (done_n == 0) done_a = t; else done_b = t;
            done_n++;
         end
         if (t == 13) begin
            n_checks++;
            if (wr_cnt !== 5'd2) begin
               n_fails++;
               $display("FAIL ignore_wr_cnt: got %0d want 2", wr_cnt);
            end
         end
         if (t == 14) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fails++;
               $display("FAIL ignore_done_start: got busy=%b want 0", busy);
            end
         end
         if (t == 15) begin
            n_checks++;
            if (wr_cnt !== 5'd0 || busy !== 1'b1) begin
               n_fails++;
               $display("FAIL restart_clear: got wr_cnt=%0d busy=%b want 0 1", wr_cnt, busy);
            end
         end
         step();
      end
      n_checks++;
      if (done_n != 2 || done_a != 13 || done_b != 26) begin
         n_fails++;
         $display("FAIL ignore_done_times: got n=%0d at %0d,%0d want 2 at 13,26", done_n, done_a, done_b);
      end
   endtask

   task automatic test_reset_mid();
      int stray, done_at;
      stray = 0; done_at = -1;
      plan_run(6, -100, 0);
      for (int t = 0; t < 16; t++) begin
         start = (t == 0); num_q = 5'd6; psum_wr = 1'b0;
         reset = (t == 11);
         if (t == 12) begin
            exp_q.delete();
            n_checks++;
            if ({kmem_ren, kmem_addr, qmem_ren, qmem_addr, q_in, i_inst, busy, done,
                 err_timeout, wr_cnt} !== '0) begin
               n_fails++;
               $display("FAIL midreset_outputs: got qren=%b qaddr=%0d inst=%b busy=%b wr=%0d want all 0",
                        qmem_ren, qmem_addr, i_inst, busy, wr_cnt);
            end
         end
         if (t >= 12 && (kmem_ren || qmem_ren || busy)) stray++;
         step();
      end
      n_checks++;
      if (stray != 0) begin
         n_fails++;
         $display("FAIL midreset_quiet: got %0d active cycles want 0", stray);
      end
      plan_run(2, -100, 0);
      for (int t = 0; t < 18; t++) begin
         start = (t == 0); num_q = 5'd2;
         psum_wr = (t == 11 || t == 12);
         if (done && done_at < 0) done_at = t;
         if (t == 1) begin
            n_checks++;
            if (kmem_ren !== 1'b1 || kmem_addr !== 4'd0) begin
               n_fails++;
               $display("FAIL midreset_rerun_kaddr: got ren=%b addr=%0d want 1 0", kmem_ren, kmem_addr);
            end
         end
         step();
      end
      n_checks++;
      if (done_at != 13) begin
         n_fails++;
         $display("FAIL midreset_rerun_done: got %0d want 13", done_at);
      end
   endtask

   task automatic test_timeout();
      int done_n, done_a, done_b;
      done_n = 0; done_a = -1; done_b = -1;
      plan_run(2, -100, 0);
      for (int t = 0; t < 42; t++) begin
         start = (t == 0 || t == 24);
         num_q = (t == 24) ? 5'd1 : 5'd2;
         psum_wr = (t == 12 || t == 35);
         if (t == 24) plan_run(1, -100, 0);
         if (done) begin
            if (done_n == 0) done_a = t; else done_b = t;
            done_n++;
         end
         if (t == 18) begin
            n_checks++;
            if (err_timeout !== 1'b0) begin
               n_fails++;
               $display("FAIL timeout_early: got err=%b want 0", err_timeout);
            end
         end
         if (t == 19) begin
            n_checks++;
            if (err_timeout !== 1'b1 || done !== 1'b1) begin
               n_fails++;
               $display("FAIL timeout_fire: got err=%b done=%b want 1 1", err_timeout, done);
            end
         end
         if (t == 22) begin
            n_checks++;
            if (err_timeout !== 1'b1 || busy !== 1'b0 || wr_cnt !== 5'd1) begin
               n_fails++;
               $display("FAIL timeout_sticky: got err=%b busy=%b wr=%0d want 1 0 1", err_timeout, busy, wr_cnt);
            end
         end
         if (t == 25) begin
            n_checks++;
            if (err_timeout !== 1'b0) begin
               n_fails++;
               $display("FAIL timeout_clear: got err=%b want 0", err_timeout);
            end
         end
         step();
      end
      n_checks++;
      if (done_n != 2 || done_a != 19 || done_b != 36) begin
         n_fails++;
         $display("FAIL timeout_done_times: got n=%0d at %0d,%0d want 2 at 19,36", done_n, done_a, done_b);
      end
   endtask

   task automatic test_full_depth();
      int qren_n, done_at;
      qren_n = 0; done_at = -1;
      plan_run(16, -100, 0);
      for (int t = 0; t < 30; t++) begin
         start = (t == 0); num_q = 5'd16;
         psum_wr = (t >= 10 && t <= 26);
         if (qmem_ren) begin
            n_checks++;
            if (qmem_addr !== 4'(qren_n)) begin
               n_fails++;
               $display("FAIL full_qaddr: got %0d want %0d", qmem_addr, qren_n);
            end
            qren_n++;
         end
         if (done && done_at < 0) done_at = t;
         if (t == 27) begin
            n_checks++;
            if (wr_cnt !== 5'd16 || busy !== 1'b0) begin
               n_fails++;
               $display("FAIL full_saturate: got wr_cnt=%0d busy=%b want 16 0", wr_cnt, busy);
            end
         end
         step();
      end
      psum_wr = 1'b0;
      n_checks++;
      if (qren_n != 16 || done_at != 26) begin
         n_fails++;
         $display("FAIL full_counts: got qren=%0d done_at=%0d want 16 26", qren_n, done_at);
      end
   endtask

   initial begin
      n_checks = 0; n_fails = 0; mon_en = 1'b0;
      reset = 1'b1; start = 1'b0; num_q = '0; ofifo_full = 1'b0; psum_wr = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_zero_q();
      test_start_ignored();
      test_reset_mid();
      test_timeout();
      test_full_depth();
      repeat (2) step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL stream_leftover: got %0d pending beats want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequencer for a chain of mac_col instances.
- Reads kernel rows from kmem and broadcasts them with inst=01 (kernel load); after a propagation gap, reads query rows from qmem and streams them with inst=10 (execute).
- Counts psum write strobes from the last column to detect completion.
- Sits between the activation/kernel SRAMs and the q_in/i_inst inputs of column 0.

Parameters:
bw, 8, bits per element
pr, 8, elements per row; q_in width = bw*pr
col, 8, number of chained columns = kernel rows loaded
aw, 4, SRAM address width
gap_cyc, 8, idle inst=00 cycles between last load beat and first exec issue
to_cyc, 64, max drain cycles after last exec beat before timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle start pulse, honoured only in IDLE
num_q  in  aw+1  query count, latched at start, 0..2^aw
ofifo_full  in  1  output FIFO full; stalls exec issue
psum_wr  in  1  fifo_wr of last column, one pulse per finished query
kmem_ren  out  1  kernel SRAM read enable
kmem_addr  out  aw  kernel SRAM address
kmem_rdata  in  bw*pr  kernel data, valid cycle after ren
qmem_ren  out  1  query SRAM read enable
qmem_addr  out  aw  query SRAM address
qmem_rdata  in  bw*pr  query data, valid cycle after ren
q_in  out  bw*pr  row to column 0
i_inst  out  2  01 = load kernel, 10 = execute, 00 = idle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err_timeout  out  1  sticky; cleared by reset or next accepted start
wr_cnt  out  aw+1  psum_wr pulses counted this run

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; counters cleared. Reset mid-run aborts immediately; no further ren is issued.
- Registered outputs: ren/addr are registered.
- Issue-to-data latency: a read issued (ren=1) in cycle n returns data in cycle n+1. The controller registers rdata and the matching inst together, so q_in and i_inst are valid in cycle n+2.
- Bubble cycles: a cycle with no read issued produces i_inst=00 and q_in=0 two cycles later.
- IDLE: when start=1, latch num_q, clear wr_cnt and err_timeout, then go to LOAD.
- LOAD: issue kmem reads at addresses 0..col-1 on consecutive cycles with no stalls. This yields exactly col consecutive i_inst=01 beats. Go to GAP after the last issue.
- GAP: count gap_cyc cycles with no reads issued. If latched num_q=0, go to DONE; else go to EXEC.
- EXEC: issue qmem reads at addresses 0..num_q-1.
  - If ofifo_full=1 in a cycle, no read is issued and the address holds. This produces an inst=00 bubble.
  - A stall on the final beat delays the exit from EXEC.
  - After the last issue, go to DRAIN.
- DRAIN: wait until wr_cnt==num_q, then go to DONE. If to_cyc cycles elapse first, set err_timeout and go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy is still 1 in DONE and drops in the following cycle.
- psum_wr counting: pulses increment wr_cnt in any non-IDLE state, including before DRAIN.
  - wr_cnt saturates at 2^aw.
  - Pulses beyond num_q are counted but do not alter completion.
- start while busy is ignored, including start coincident with done.
- The addr width covers 2^aw entries. num_q=2^aw reads addresses 0..2^aw-1 without wrap.

Test Plan:
1. col=3, gap_cyc=4, num_q=3; kmem rows A,B,C; qmem rows X,Y,Z; return 3 psum_wr pulses.
   -> kmem_addr 0,1,2. i_inst=01 for exactly 3 cycles carrying A,B,C, 2 cycles after each ren. 4 idle cycles, then i_inst=10 carrying X,Y,Z. done pulses 1 cycle after the 3rd psum_wr; wr_cnt=3; busy falls the next cycle.
2. num_q=4; hold ofifo_full=1 for 2 cycles after the 2nd exec issue.
   -> qmem_addr holds at 2. Exactly two i_inst=00 bubbles appear between beats 2 and 3. Four 10-beats in total.
3. num_q=0.
   -> 3 load beats, gap, then done. No qmem_ren ever asserted.
4. Pulse start during EXEC and again coincident with done.
   -> Both are ignored. A start one cycle after done begins a new run with wr_cnt cleared.
5. Assert reset during the 2nd exec beat.
   -> Next cycle: all outputs 0, busy=0, no ren. A later start runs cleanly from kmem address 0.
6. num_q=2, to_cyc=10, only 1 psum_wr returned.
   -> err_timeout=1 and done pulse 10 cycles after the last exec issue. err_timeout stays 1 until the next accepted start.
